if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction prefetch buffer directly upstream of the IF stage. Runs ahead of IF, issuing
//  in-order reads to instruction memory and queueing {pc, instr} pairs for IF to consume.
//  Absorbs variable memory latency and IF stalls.
//  Flushes on any PC redirect (branch, call, ret).
// PARAMETERS
//  DEPTH     4        queue entries (power of 2, >=2); also max in-flight + queued total
//  RESET_PC  16'h0000 first fetch address after reset
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   synchronous, active-high reset
//  hlt           in   1   halt: no new memory requests while high
//  stall         in   1   IF not accepting this cycle
//  redirect      in   1   PC redirect (branch taken / call / ret)
//  redirect_pc   in   16  redirect target
//  imem_req      out  1   read request, one per cycle max, never back-pressured
//  imem_addr     out  16  word address of request
//  imem_rvalid   in   1   response valid; responses return in request order
//  imem_rdata    in   16  response instruction
//  valid         out  1   head entry valid for IF
//  instr         out  16  head instruction; NOP_INSTR when !valid
//  pc            out  16  address of head instruction
//  pc_inc        out  16  pc + 1 (word-addressed), wraps 16'hFFFF -> 16'h0000
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0; outputs valid=0,
//   instr=NOP_INSTR, pc=0, pc_inc=0 (pc/pc_inc are 0 whenever valid=0),
//   imem_req=0, imem_addr=0. Reset wins over all other inputs, including mid-operation.
//  Issue: imem_req=1 iff !rst && !redirect && !hlt && (count+outstanding) < DEPTH;
//   imem_addr=fetch_pc; on issue fetch_pc<=fetch_pc+1 (mod 2^16), outstanding++.
//  Response: each imem_rvalid decrements outstanding. If drop_cnt>0, data is discarded and
//   drop_cnt--. Otherwise {addr,rdata} is pushed (addr tracked by in-order resp_pc counter).
//   Credit rule guarantees push never overflows.
//  Consume: pop when valid && !stall. Same-cycle push+pop allowed; count unchanged.
//  Latency: req at cycle t, rvalid at t+L, valid/instr at IF at t+L+1 (registered head,
//   no combinational bypass from imem_rdata).
//  Redirect (highest priority after rst): queue cleared; any same-cycle pop/push ignored;
//   fetch_pc<=redirect_pc; resp_pc<=redirect_pc; no request issued that cycle;
//   drop_cnt<=outstanding - imem_rvalid (all older in-flight reads dropped).
//   valid=0 the following cycle. First new request is issued the cycle after redirect.
//   Back-to-back redirects: the latest target wins; drop_cnt recomputed each time.
//  hlt: blocks issue only; in-flight responses still land; queued entries still drain.
//   hlt with redirect: fetch_pc updated, no issue until hlt drops.
//  Full: count+outstanding==DEPTH -> imem_req=0 until a pop or redirect frees credit.
//  Empty: valid=0, instr=NOP_INSTR, pc=0, pc_inc=0.
//  Invariants: count<=DEPTH; outstanding<=DEPTH; drop_cnt<=outstanding. Bench asserts
//   imem_rvalid never arrives with outstanding==0.
// STRUCTURE
//  cpu_pkg: WORD_W=16, NOP_INSTR, typedef pf_entry_t {logic[15:0] pc; logic[15:0] instr;}.
//  Sub-module pf_fifo #(DEPTH, type T): sync FIFO with push/pop/clear, count, registered
//   head. Top level holds fetch_pc, resp_pc, the outstanding and drop_cnt counters, and
//   issue/credit logic.
// TESTING
//  1 Reset, L=1 mem, stall=0 -> imem_addr 0,1,2...; valid from cycle 3; pc 0,1,2; pc_inc=pc+1.
//  2 stall=1 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req=0;
//    release stall -> entries popped pc 0..3 in order; issue resumes at 4.
//  3 L=3, 3 reads in flight, redirect to 16'h0040 -> all 3 responses dropped;
//    next valid shows pc=16'h0040 with data from addr 0x40.
//  4 Redirect in the same cycle as imem_rvalid and pop -> response dropped;
//    drop_cnt=outstanding-1; valid=0 next cycle; count=0.
//  5 RESET_PC=16'hFFFE, free-run -> addresses FFFE, FFFF, 0000; pc_inc at FFFF = 0000.
//  6 hlt=1 mid-stream -> no new req; queued+in-flight drain to IF; hlt=0 resumes at next pc.
//    rst mid-flight -> all outputs at reset values next cycle; late rvalid ignored by bench model.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   WORD_W     : instruction and address width (word addressed)
//   NOP_INSTR  : instruction presented to IF whenever no fetched entry is available
//   pf_entry_t : one prefetch queue entry, the fetch address paired with its instruction
//   word_inc   : next sequential word address, wrapping 16'hFFFF -> 16'h0000
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } pf_entry_t;

    function automatic logic [WORD_W-1:0] word_inc(input logic [WORD_W-1:0] addr);
        return addr + WORD_W'(1);
    endfunction

endpackage

// File: rtl/pf_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// The head is read straight from the storage registers, so a pushed entry
// becomes visible one cycle after the push (no bypass from push_data).
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset, empties the FIFO
//   clear      in   synchronous flush, same effect as rst
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   entry to write
//   pop        in   drop the head entry (ignored when empty)
//   head       out  oldest entry, meaningful only when !empty
//   count      out  number of stored entries, 0..DEPTH
//   empty      out  count == 0
module pf_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset; stale slots are unreachable once the pointers
    // are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch buffer sitting directly in front of the IF stage.
// Runs ahead of IF issuing in-order instruction memory reads and queues the
// returned {pc, instr} pairs, absorbing memory latency and IF stalls. Any PC
// redirect flushes the queue and discards all reads still in flight.
// Ports:
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   hlt          in   halt: suppresses new memory requests only
//   stall        in   IF is not accepting the head entry this cycle
//   redirect     in   PC redirect (taken branch / call / ret)
//   redirect_pc  in   redirect target
//   imem_req     out  read request, at most one per cycle, never back-pressured
//   imem_addr    out  word address of the request (0 when no request)
//   imem_rvalid  in   response valid, responses return in request order
//   imem_rdata   in   response instruction
//   valid        out  head entry valid for IF
//   instr        out  head instruction, NOP_INSTR when !valid
//   pc           out  head address, 0 when !valid
//   pc_inc       out  head address + 1 (wrapping), 0 when !valid
module if_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_inc
);

    localparam int           CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);

    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic              q_valid;
    pf_entry_t         q_head;
    pf_entry_t         push_entry;
    logic [CW:0]       credit_used;
    logic              issue;
    logic              do_push;
    logic              do_pop;
    logic              resp_dropped;

    // Queued entries plus reads in flight may never exceed DEPTH; this is
    // what guarantees every response has a free slot when it lands.
    assign credit_used  = {1'b0, q_count} + {1'b0, outstanding};
    assign issue        = !rst && !redirect && !hlt && (credit_used < DEPTH_W);

    // Responses belonging to a pre-redirect stream are discarded; a redirect
    // in the same cycle also discards the response arriving with it.
    assign resp_dropped = (drop_cnt != '0);
    assign do_push      = imem_rvalid && !resp_dropped && !redirect && !rst;
    assign q_valid      = !q_empty;
    assign do_pop       = q_valid && !stall && !redirect && !rst;

    assign push_entry.pc    = resp_pc;
    assign push_entry.instr = imem_rdata;

    pf_fifo #(
        .DEPTH (DEPTH),
        .T     (pf_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (do_push),
        .push_data (push_entry),
        .pop       (do_pop),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

    // Fetch/response address tracking and the in-flight / drop counters.
    // resp_pc only advances on kept responses, so after a redirect it lines up
    // with the first read issued to the new target.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= outstanding - CW'(imem_rvalid);
            drop_cnt    <= outstanding - CW'(imem_rvalid);
        end else begin
            if (issue) begin
                fetch_pc <= word_inc(fetch_pc);
            end
            if (do_push) begin
                resp_pc <= word_inc(resp_pc);
            end
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
            if (imem_rvalid && resp_dropped) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Memory request and IF-facing outputs; everything IF sees comes from
    // the registered queue head and is forced to idle values when empty.
    always_comb begin
        imem_req  = issue;
        imem_addr = '0;
        valid     = q_valid;
        instr     = NOP_INSTR;
        pc        = '0;
        pc_inc    = '0;
        if (issue) begin
            imem_addr = fetch_pc;
        end
        if (q_valid) begin
            instr  = q_head.instr;
            pc     = q_head.pc;
            pc_inc = word_inc(q_head.pc);
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: a queue-based reference model of
// the prefetcher plus an in-order variable-latency instruction memory.
// A second instance with RESET_PC=16'hFFFE checks address wrap-around.
module tb_if_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [15:0] NOP   = 16'h0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        rst = 1'b1;
    logic        hlt = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_inc;

    // Wrap-around instance
    logic        rst_w = 1'b1;
    logic        req_w;
    logic [15:0] addr_w;
    logic        rvalid_w = 1'b0;
    logic [15:0] rdata_w = 16'h0000;
    logic        valid_w;
    logic [15:0] instr_w;
    logic [15:0] pc_w;
    logic [15:0] pc_inc_w;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .hlt(hlt), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .valid(valid), .instr(instr), .pc(pc), .pc_inc(pc_inc)
    );

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst(rst_w), .hlt(1'b0), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(16'h0000),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
        .valid(valid_w), .instr(instr_w), .pc(pc_w), .pc_inc(pc_inc_w)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Reference model state
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        m_q[$];
    int          m_out   = 0;
    int          m_drop  = 0;
    logic [15:0] m_fetch = 16'h0000;
    logic [15:0] m_resp  = 16'h0000;

    // Memory model: pending request addresses and their response cycles
    logic [15:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          last_due = 0;

    // Stimulus for the next cycle
    logic        s_rst = 1'b1, s_hlt = 1'b0, s_stall = 1'b0, s_redir = 1'b0;
    logic [15:0] s_rpc = 16'h0000;

    // Observed DUT outputs of the last checked cycle
    logic        o_valid, o_req;
    logic [15:0] o_addr, o_pc, o_instr, o_pc_inc;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C69;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        cyc++;
        rst         = s_rst;
        hlt         = s_hlt;
        stall       = s_stall;
        redirect    = s_redir;
        redirect_pc = s_rpc;
        if (!s_rst && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(mem_addr_q[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
    endtask

    // Compare all outputs against the model on the falling edge
    task automatic checkOutput();
        logic        ev;
        logic        er;
        logic [15:0] epc;
        @(negedge clk);
        ev  = (m_q.size() > 0);
        er  = !rst && !redirect && !hlt && ((m_q.size() + m_out) < DEPTH);
        epc = ev ? m_q[0].pc : 16'h0000;
        cmp("valid", 16'(valid), 16'(ev));
        cmp("instr", instr, ev ? m_q[0].instr : NOP);
        cmp("pc", pc, epc);
        cmp("pc_inc", pc_inc, ev ? 16'(epc + 16'd1) : 16'h0000);
        cmp("imem_req", 16'(imem_req), 16'(er));
        cmp("imem_addr", imem_addr, er ? m_fetch : 16'h0000);
        if (imem_rvalid && !rst) begin
            cmp("rvalid_has_outstanding", 16'(m_out > 0), 16'd1);
        end
        o_valid  = valid;
        o_req    = imem_req;
        o_addr   = imem_addr;
        o_pc     = pc;
        o_instr  = instr;
        o_pc_inc = pc_inc;
    endtask

    // Advance the model and the memory by one clock edge
    task automatic modelStep();
        ent_t e;
        logic er;
        int   due;
        er = !rst && !redirect && !hlt && ((m_q.size() + m_out) < DEPTH);
        if (rst) begin
            m_q.delete();
            m_fetch = 16'h0000;
            m_resp  = 16'h0000;
            m_out   = 0;
            m_drop  = 0;
            mem_addr_q.delete();
            mem_due_q.delete();
            last_due = cyc;
            return;
        end
        if (redirect) begin
            m_q.delete();
            if (imem_rvalid) m_out--;
            m_drop  = m_out;
            m_fetch = redirect_pc;
            m_resp  = redirect_pc;
        end else begin
            if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
            if (imem_rvalid) begin
                m_out--;
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    e.pc    = m_resp;
                    e.instr = imem_rdata;
                    m_q.push_back(e);
                    m_resp  = m_resp + 16'd1;
                end
            end
            if (er) begin
                m_out++;
                m_fetch = m_fetch + 16'd1;
            end
        end
        if (imem_rvalid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (imem_req) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(due);
            last_due = due;
        end
    endtask

    task automatic runCycle();
        applyStimulus();
        checkOutput();
        modelStep();
    endtask

    task automatic setIdle();
        s_rst = 1'b0; s_hlt = 1'b0; s_stall = 1'b0; s_redir = 1'b0; s_rpc = 16'h0000;
    endtask

    task automatic doReset(input int n);
        setIdle();
        s_rst = 1'b1;
        for (int i = 0; i < n; i++) runCycle();
        s_rst = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_addr_w [3];
        logic [15:0] popped[$];
        logic        prev_req;
        logic [15:0] prev_addr;
        int          first_valid;
        int          first_addr;
        int          nreq;
        bit          found;

        // Wrap-around at the top of the address space (main DUT held in reset)
        exp_addr_w = '{16'hFFFE, 16'hFFFF, 16'h0000};
        prev_req   = 1'b0;
        prev_addr  = 16'h0000;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            rst_w    = 1'b0;
            rvalid_w = prev_req;
            rdata_w  = memfn(prev_addr);
            @(negedge clk);
            cmp("wrap_req", 16'(req_w), 16'd1);
            if (k < 3) cmp("wrap_addr", addr_w, exp_addr_w[k]);
            if (k == 2) cmp("wrap_pc_fffe", pc_w, 16'hFFFE);
            if (k == 3) begin
                cmp("wrap_pc_ffff", pc_w, 16'hFFFF);
                cmp("wrap_pc_inc_ffff", pc_inc_w, 16'h0000);
                cmp("wrap_instr_ffff", instr_w, 16'hC396);
            end
            if (k == 4) begin
                cmp("wrap_pc_0000", pc_w, 16'h0000);
                cmp("wrap_pc_inc_0000", pc_inc_w, 16'h0001);
            end
            prev_req  = req_w;
            prev_addr = addr_w;
        end
        @(posedge clk);
        #1;
        rst_w    = 1'b1;
        rvalid_w = 1'b0;

        // Free-run, single-cycle memory
        $display("[TB] phase: free run L=1");
        lat_min = 1; lat_max = 1;
        doReset(2);
        first_valid = -1;
        popped.delete();
        for (int k = 0; k < 10; k++) begin
            runCycle();
            if (k < 3) cmp("p1_addr", o_addr, 16'(k));
            if (o_valid && first_valid < 0) first_valid = k;
            if (o_valid && popped.size() < 3) begin
                popped.push_back(o_pc);
                cmp("p1_pc_inc", o_pc_inc, 16'(popped.size()));
            end
        end
        cmp("p1_first_valid_cycle", 16'(first_valid), 16'd2);
        for (int i = 0; i < 3; i++) cmp("p1_pc", (i < popped.size()) ? popped[i] : 16'hDEAD, 16'(i));

        // Stalled IF fills the credit window, then drains in order
        $display("[TB] phase: stall fill");
        doReset(2);
        s_stall = 1'b1;
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            runCycle();
            nreq += int'(o_req);
        end
        cmp("p2_req_count", 16'(nreq), 16'd4);
        cmp("p2_req_when_full", 16'(o_req), 16'd0);
        s_stall = 1'b0;
        popped.delete();
        first_addr = -1;
        for (int k = 0; k < 12; k++) begin
            runCycle();
            if (o_valid && popped.size() < 4) popped.push_back(o_pc);
            if (o_req && first_addr < 0) first_addr = int'(o_addr);
        end
        for (int i = 0; i < 4; i++) cmp("p2_drain_pc", (i < popped.size()) ? popped[i] : 16'hDEAD, 16'(i));
        cmp("p2_resume_addr", 16'(first_addr), 16'd4);

        // Redirect with three reads in flight
        $display("[TB] phase: redirect L=3");
        lat_min = 3; lat_max = 3;
        doReset(2);
        repeat (3) runCycle();
        s_redir = 1'b1; s_rpc = 16'h0040;
        runCycle();
        s_redir = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            runCycle();
            if (o_valid) begin
                found = 1'b1;
                cmp("p3_first_pc", o_pc, 16'h0040);
                cmp("p3_first_instr", o_instr, 16'h7C69);
            end
        end
        cmp("p3_valid_seen", 16'(found), 16'd1);

        // Redirect coinciding with a response and a pop
        $display("[TB] phase: redirect with rvalid and pop");
        lat_min = 2; lat_max = 2;
        doReset(2);
        repeat (6) runCycle();
        s_redir = 1'b1; s_rpc = 16'h1230;
        runCycle();
        cmp("p4_valid_at_redirect", 16'(o_valid), 16'd1);
        s_redir = 1'b0;
        runCycle();
        cmp("p4_valid_after_redirect", 16'(o_valid), 16'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            runCycle();
            if (o_valid) begin
                found = 1'b1;
                cmp("p4_first_pc", o_pc, 16'h1230);
                cmp("p4_first_instr", o_instr, 16'h0C7B);
            end
        end
        cmp("p4_valid_seen", 16'(found), 16'd1);

        // Halt drains, redirect under halt, reset mid-flight
        $display("[TB] phase: halt and mid-flight reset");
        doReset(2);
        repeat (5) runCycle();
        s_hlt = 1'b1;
        nreq = 0;
        for (int k = 0; k < 8; k++) begin
            runCycle();
            nreq += int'(o_req);
        end
        cmp("p6_req_during_hlt", 16'(nreq), 16'd0);
        cmp("p6_drained", 16'(o_valid), 16'd0);
        s_redir = 1'b1; s_rpc = 16'h0800;
        runCycle();
        s_redir = 1'b0;
        nreq = 0;
        for (int k = 0; k < 3; k++) begin
            runCycle();
            nreq += int'(o_req);
        end
        cmp("p6_req_hlt_redirect", 16'(nreq), 16'd0);
        s_hlt = 1'b0;
        runCycle();
        cmp("p6_resume_addr", o_addr, 16'h0800);
        lat_min = 3; lat_max = 3;
        repeat (4) runCycle();
        s_rst = 1'b1;
        runCycle();
        cmp("p6_req_in_reset", 16'(o_req), 16'd0);
        s_rst = 1'b0;
        runCycle();
        cmp("p6_valid_after_reset", 16'(o_valid), 16'd0);
        cmp("p6_addr_after_reset", o_addr, 16'h0000);

        // Randomised traffic
        $display("[TB] phase: random");
        lat_min = 1; lat_max = 4;
        doReset(2);
        for (int k = 0; k < 3000; k++) begin
            s_rst   = ($urandom_range(299, 0) == 0);
            s_redir = !s_rst && ($urandom_range(23, 0) == 0);
            s_rpc   = ($urandom_range(3, 0) == 0) ? (16'hFFFC + 16'($urandom_range(3, 0)))
                                                  : 16'($urandom);
            if ($urandom_range(15, 0) == 0) s_hlt = !s_hlt;
            s_stall = ($urandom_range(2, 0) == 0);
            runCycle();
        end
        setIdle();
        repeat (10) runCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
